imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, word-address width of instruction memory (2^ADDR_W words).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle pulse that begins a load.
REQ-005 SHALL have port: word_count  input  ADDR_W+1  number of words to load; sampled on start.
REQ-006 SHALL have port: byte_valid  input  1  source has a byte on byte_data.
REQ-007 SHALL have port: byte_data  input  8  program byte stream, little-endian within each word.
REQ-008 SHALL have port: byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port: mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port: mem_addr  output  32  byte address of the write (word index * 4).
REQ-011 SHALL have port: mem_wdata  output  32  word to write.
REQ-012 SHALL have port: cpu_hold  output  1  holds the CPU in reset while loading.
REQ-013 SHALL have port: busy  output  1  load in progress.
REQ-014 SHALL have port: done  output  1  sticky; load finished.
REQ-015 SHALL have port: error  output  1  sticky; checksum mismatch.

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK, DONE; CHECK exists only with the checksum feature.
REQ-017 start in IDLE or DONE SHALL clear done and error, latch word_count, zero word index and byte counter, and enter LOAD next cycle; start in LOAD or CHECK SHALL be ignored.
REQ-018 word_count = 0 at start SHALL go directly to DONE (done=1 next cycle) with no writes and no byte accepted.
REQ-019 word_count > 2^ADDR_W SHALL be clamped to 2^ADDR_W.
REQ-020 byte_ready SHALL be high only in LOAD/CHECK while bytes remain to be received; a byte transfers when byte_valid and byte_ready are both high.
REQ-021 the k-th accepted byte of a word (k=0..3) SHALL occupy bits [8k+7:8k].
REQ-022 the cycle after the 4th byte of a word is accepted, mem_we SHALL be 1 for exactly one cycle with mem_addr = index*4 and mem_wdata = assembled word; index then increments.
REQ-023 acceptance SHALL sustain one byte per cycle; a byte accepted during a write cycle SHALL go to the next word without corrupting mem_wdata.
REQ-024 mem_addr and mem_wdata SHALL hold their last values when mem_we = 0.
REQ-025 byte_valid low SHALL stall the loader indefinitely with no timeout and no state change.
REQ-026 after the last word's write cycle the FSM SHALL enter DONE (or CHECK); done SHALL rise in the DONE-entry cycle and remain high until the next start or reset.
REQ-027 cpu_hold and busy SHALL be 1 exactly while in LOAD or CHECK.

Reset
REQ-028 reset SHALL immediately force IDLE; byte_ready, mem_we, cpu_hold, busy, done, error = 0; mem_addr, mem_wdata = 0.
REQ-029 reset mid-load SHALL discard any partial word and issue no further writes; already-written words are not undone.

Configuration
REQ-030 macro IMEM_LOADER_CHECKSUM_EN defined: after the last data word, one further 4-byte word SHALL be received in CHECK (never written to memory) and compared with the modulo-2^32 sum of all written words; mismatch sets error=1; done=1 in both cases.
REQ-031 macro undefined: no CHECK state, no extra word, error tied to 0.

Verification
REQ-032 word_count=2, bytes 13 00 00 00 93 00 10 00 back-to-back -> writes (0x0, 0x00000013), (0x4, 0x00100093); done=1 in cycle after 2nd write; cpu_hold high only during LOAD.
REQ-033 word_count=1, byte_valid toggled every other cycle -> single write 0xDEADBEEF at 0x0 from bytes EF BE AD DE; no byte lost or duplicated.
REQ-034 reset asserted after 6 of 8 bytes -> all outputs 0 within the reset cycle, only one write observed, later start works normally.
REQ-035 word_count=0 -> done=1 next cycle, mem_we never asserted, byte_ready stays 0; start during LOAD ignored.
REQ-036 with IMEM_LOADER_CHECKSUM_EN: words 0x1, 0x2 then checksum 0x3 -> error=0, done=1; repeat with checksum 0x4 -> error=1, done=1; only 2 writes each.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian words, writes them, holds the CPU meanwhile.
// Optional trailing checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR_W:0] word_count,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
`endif

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_e          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] index_q, index_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     asm_q, asm_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            done_q, done_d;
  logic            accept;
  logic [31:0]     word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic            error_q, error_d;
  logic [31:0]     sum_q, sum_d;
`endif

  // Only the first three bytes are buffered; the fourth goes straight into the write register.
  function automatic logic [23:0] put_byte(input logic [23:0] a, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [23:0] r;
    r = a;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      default: r[23:16] = b;
    endcase
    return r;
  endfunction

  assign accept = byte_valid & byte_ready;
  assign word   = {byte_data, asm_q};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    byte_ready  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    error_d     = error_q;
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          count_d = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
          index_d = '0;
          bcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          error_d = 1'b0;
          sum_d   = '0;
`endif
          if (word_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
            done_d  = 1'b0;
          end
        end
      end
      LOAD: begin
        byte_ready = (index_q != count_q);
        if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {{(30 - ADDR_W){1'b0}}, index_q[ADDR_W-1:0], 2'b00};
            mem_wdata_d = word;
            index_d     = index_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d       = sum_q + word;
`endif
          end else begin
            asm_d = put_byte(asm_q, bcnt_q, byte_data);
          end
        end else if (index_q == count_q) begin
          // Reached only in the last word's write cycle, so done follows that write.
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            error_d = (word != sum_q);
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            asm_d = put_byte(asm_q, bcnt_q, byte_data);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      index_q     <= '0;
      bcnt_q      <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      error_q     <= 1'b0;
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      bcnt_q      <= bcnt_d;
      asm_q       <= asm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      error_q     <= error_d;
      sum_q       <= sum_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy  = (state_q == LOAD) || (state_q == CHECK);
  assign error = error_q;
`else
  assign busy  = (state_q == LOAD);
  assign error = 1'b0;
`endif
  assign cpu_hold  = busy;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a queue-based reference model.
module tb_imem_loader;
  localparam int unsigned AW   = 4;
  localparam int          MAXW = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [AW:0]   word_count;
  logic [7:0]    byte_data;
  logic          byte_ready, mem_we, cpu_hold, busy, done, error;
  logic [31:0]   mem_addr, mem_wdata;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t         obs_q[$];
  logic [7:0]  src_q[$];
  logic        prev_we = 1'b0;
  logic [31:0] exp_last_a = '0;
  logic [31:0] exp_last_d = '0;

  always @(negedge clk) begin
    if (mem_we) begin
      obs_q.push_back({mem_addr, mem_wdata});
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = mem_we;
  end

  task automatic fill_rand(input int nbytes);
    src_q.delete();
    for (int i = 0; i < nbytes; i++) src_q.push_back(8'($urandom));
  endtask

  // ck_mode: 0 leave trailing bytes as-is, 1 make them the correct checksum, 2 correct checksum + 1
  task automatic do_load(input int n_req, input int vmode, input int inject, input int ck_mode);
    int          n_eff, need, idx, cycles, last_we;
    bit          fin, toggle, exp_err;
    logic [31:0] sum, w, ck;
    wr_t         exp_q[$];
    n_eff = (n_req > MAXW) ? MAXW : n_req;
    need  = n_eff * 4 + ((CHK && n_eff > 0) ? 4 : 0);
    sum   = '0;
    for (int i = 0; i < n_eff; i++) begin
      w = {src_q[4*i+3], src_q[4*i+2], src_q[4*i+1], src_q[4*i]};
      exp_q.push_back({32'(i * 4), w});
      sum += w;
    end
    if (n_eff > 0 && ck_mode != 0) begin
      ck = (ck_mode == 1) ? sum : sum + 32'd1;
      for (int k = 0; k < 4; k++) src_q[n_eff*4 + k] = ck[8*k +: 8];
    end
    ck      = (n_eff > 0) ? {src_q[n_eff*4+3], src_q[n_eff*4+2], src_q[n_eff*4+1], src_q[n_eff*4]} : '0;
    exp_err = CHK && (n_eff > 0) && (ck != sum);
    obs_q.delete();
    idx = 0; cycles = 0; last_we = -10; fin = 1'b0; toggle = 1'b1;
    start = 1'b1; word_count = n_req[AW:0];
    @(negedge clk);
    start = 1'b0;
    while (!fin && cycles < 3000) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        chk("busy_during_load", {31'd0, busy}, 32'd1);
        chk("cpu_hold_during_load", {31'd0, cpu_hold}, 32'd1);
        if (mem_we) last_we = cycles;
        case (vmode)
          0:       byte_valid = 1'b1;
          1:       byte_valid = toggle;
          default: byte_valid = ($urandom_range(0, 3) != 0);
        endcase
        toggle = ~toggle;
        if (idx >= src_q.size()) byte_valid = 1'b0;
        byte_data = byte_valid ? src_q[idx] : 8'($urandom);
        if (byte_valid && byte_ready) idx++;
        if (inject != 0 && cycles == 3) begin
          start = 1'b1; word_count = '0;
        end else begin
          start = 1'b0; word_count = n_req[AW:0];
        end
        cycles++;
        @(negedge clk);
      end
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    chk("load_finished", {31'd0, fin}, 32'd1);
    if (n_eff == 0) chk("zero_count_done_latency", cycles, 0);
    else if (!CHK) chk("done_after_last_write", cycles, last_we + 1);
    chk("n_writes", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk("write_addr", obs_q[i].a, exp_q[i].a);
      chk("write_data", obs_q[i].d, exp_q[i].d);
    end
    chk("bytes_accepted", idx, need);
    chk("done_flag", {31'd0, done}, 32'd1);
    chk("error_flag", {31'd0, error}, {31'd0, exp_err});
    chk("byte_ready_after", {31'd0, byte_ready}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("cpu_hold_after", {31'd0, cpu_hold}, 32'd0);
    if (n_eff > 0) begin
      exp_last_a = exp_q[n_eff-1].a;
      exp_last_d = exp_q[n_eff-1].d;
    end
    chk("hold_addr", mem_addr, exp_last_a);
    chk("hold_wdata", mem_wdata, exp_last_d);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    int          idx, guard;
    logic [31:0] w0;
    reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // two-instruction program, back-to-back bytes
    src_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
              8'h03, 8'h00, 8'h00, 8'h00, 8'h55, 8'h66};
    do_load(2, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("done_sticky", {31'd0, done}, 32'd1);

    // one word, valid toggling every other cycle
    src_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    do_load(1, 1, 0, 1);

    fill_rand(16);
    do_load(0, 0, 0, 0);
    fill_rand(24);
    do_load(3, 0, 1, 1);

    // reset after 6 of 8 bytes
    fill_rand(12);
    w0 = {src_q[3], src_q[2], src_q[1], src_q[0]};
    obs_q.delete();
    start = 1'b1; word_count = 5'd2;
    @(negedge clk);
    start = 1'b0; idx = 0; guard = 0;
    while (idx < 6 && guard < 100) begin
      byte_valid = 1'b1; byte_data = src_q[idx];
      if (byte_ready) idx++;
      guard++;
      @(negedge clk);
    end
    chk("reset_test_bytes", idx, 6);
    byte_valid = 1'b1; byte_data = src_q[6];
    #2 reset = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0; byte_valid = 1'b0;
    exp_last_a = '0; exp_last_d = '0;
    repeat (4) @(negedge clk);
    chk("reset_n_writes", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      chk("reset_write_addr", obs_q[0].a, 32'h0);
      chk("reset_write_data", obs_q[0].d, w0);
    end
    check_all_zero("after_reset");
    fill_rand(16);
    do_load(2, 2, 0, 1);

    // count above capacity is clamped
    fill_rand(31 * 4 + 8);
    do_load(31, 2, 0, 1);

    for (int t = 0; t < 8; t++) begin
      fill_rand(40);
      do_load(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 0,
              int'($urandom_range(0, 2)));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    src_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(2, 0, 0, 0);
    src_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(2, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
